// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router packet-sequencing controller.
// Holds the FSM state encoding and the default destination geometry.
package router_pkg;

  localparam int NUM_DEST_DEF = 3;
  localparam int ADDR_W_DEF   = 2;

  typedef enum logic [2:0] {
    DA  = 3'd0,
    WTE = 3'd1,
    LFD = 3'd2,
    LD  = 3'd3,
    FFS = 3'd4,
    LAF = 3'd5,
    LP  = 3'd6,
    CPE = 3'd7
  } state_t;

endpackage

// File: rtl/router_fsm.sv
// Packet-sequencing controller of the 1x3 router.
// Moore FSM driving router_reg strobes, FIFO write enable and busy.
module router_fsm
  import router_pkg::*;
#(
  parameter int NUM_DEST = NUM_DEST_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                pkt_valid,
  input  logic [ADDR_W-1:0]   data_in,
  input  logic                fifo_full,
  input  logic [NUM_DEST-1:0] fifo_empty,
  input  logic [NUM_DEST-1:0] soft_reset,
  input  logic                parity_done,
  input  logic                low_pkt_valid,
  output logic                detect_add,
  output logic                lfd_state,
  output logic                ld_state,
  output logic                laf_state,
  output logic                full_state,
  output logic                rst_int_reg,
  output logic                write_enb_reg,
  output logic                busy
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                addr_ok;
  logic                srst;

  assign addr_ok = 32'(data_in) < 32'(NUM_DEST);
  assign srst    = soft_reset[addr_q];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= DA;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      DA: begin
        if (pkt_valid && addr_ok) begin
          addr_d  = data_in;
          state_d = fifo_empty[data_in] ? LFD : WTE;
        end
      end
      WTE: begin
        if (fifo_empty[addr_q]) state_d = LFD;
      end
      LFD: state_d = LD;
      LD: begin
        if (fifo_full)       state_d = FFS;
        else if (!pkt_valid) state_d = LP;
      end
      FFS: begin
        if (!fifo_full) state_d = LAF;
      end
      LAF: begin
        if (parity_done)        state_d = DA;
        else if (low_pkt_valid) state_d = LP;
        else                    state_d = LD;
      end
      LP:  state_d = CPE;
      CPE: state_d = fifo_full ? FFS : DA;
      default: state_d = DA;
    endcase
    // A timed-out destination aborts the packet from any busy state.
    if (state_q != DA && srst) state_d = DA;
  end

  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    rst_int_reg   = 1'b0;
    write_enb_reg = 1'b0;
    busy          = 1'b1;
    unique case (1'b1)
      (state_q == DA): begin
        detect_add = 1'b1;
        busy       = 1'b0;
      end
      (state_q == LFD): lfd_state = 1'b1;
      (state_q == LD): begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
        busy          = 1'b0;
      end
      (state_q == LAF): begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
      end
      (state_q == FFS): full_state = 1'b1;
      (state_q == LP):  write_enb_reg = 1'b1;
      (state_q == CPE): rst_int_reg = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_router_fsm.sv
// Scoreboard bench for router_fsm: named-state reference model,
// directed packet scenarios followed by randomized traffic.
module tb_router_fsm;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       pkt_valid = 1'b0;
  logic [1:0] data_in = '0;
  logic       fifo_full = 1'b0;
  logic [2:0] fifo_empty = '0;
  logic [2:0] soft_reset = '0;
  logic       parity_done = 1'b0;
  logic       low_pkt_valid = 1'b0;
  logic       detect_add, lfd_state, ld_state, laf_state;
  logic       full_state, rst_int_reg, write_enb_reg, busy;

  int errors = 0;
  int checks = 0;

  string m_st = "DA";
  int    m_addr = 0;
  string exp_q[$];

  router_fsm dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid),
    .data_in(data_in), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .soft_reset(soft_reset),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state),
    .full_state(full_state), .rst_int_reg(rst_int_reg),
    .write_enb_reg(write_enb_reg), .busy(busy)
  );

  always #5 clock = ~clock;

  // Output vector {detect,lfd,ld,laf,full,rst_int,wen,busy} per state name.
  function automatic logic [7:0] outs_of(string s);
    logic [7:0] v;
    v[7] = (s == "DA");
    v[6] = (s == "LFD");
    v[5] = (s == "LD");
    v[4] = (s == "LAF");
    v[3] = (s == "FFS");
    v[2] = (s == "CPE");
    v[1] = (s == "LD") || (s == "LAF") || (s == "LP");
    v[0] = !((s == "DA") || (s == "LD"));
    return v;
  endfunction

  task automatic model_step();
    string nx;
    int    a;
    a  = int'(data_in);
    nx = m_st;
    if (reset) begin
      nx     = "DA";
      m_addr = 0;
    end else if (m_st != "DA" && soft_reset[m_addr]) begin
      nx = "DA";
    end else if (m_st == "DA") begin
      if (pkt_valid && a < 3) begin
        m_addr = a;
        nx = fifo_empty[a] ? "LFD" : "WTE";
      end
    end else if (m_st == "WTE") begin
      if (fifo_empty[m_addr]) nx = "LFD";
    end else if (m_st == "LFD") begin
      nx = "LD";
    end else if (m_st == "LD") begin
      if (fifo_full) nx = "FFS";
      else if (!pkt_valid) nx = "LP";
    end else if (m_st == "FFS") begin
      if (!fifo_full) nx = "LAF";
    end else if (m_st == "LAF") begin
      if (parity_done) nx = "DA";
      else if (low_pkt_valid) nx = "LP";
      else nx = "LD";
    end else if (m_st == "LP") begin
      nx = "CPE";
    end else if (m_st == "CPE") begin
      nx = fifo_full ? "FFS" : "DA";
    end
    m_st = nx;
  endtask

  task automatic drive(input logic rst, input logic pv,
                       input logic [1:0] din, input logic ff,
                       input logic [2:0] fe, input logic [2:0] sr,
                       input logic pd, input logic lpv);
    @(negedge clock);
    reset = rst; pkt_valid = pv; data_in = din;
    fifo_full = ff; fifo_empty = fe; soft_reset = sr;
    parity_done = pd; low_pkt_valid = lpv;
    model_step();
    exp_q.push_back(m_st);
  endtask

  initial begin : monitor
    string s;
    logic [7:0] act, exp_v;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        s = exp_q.pop_front();
        exp_v = outs_of(s);
        act = {detect_add, lfd_state, ld_state, laf_state,
               full_state, rst_int_reg, write_enb_reg, busy};
        checks++;
        if (act !== exp_v) begin
          errors++;
          $display("FAIL outs state=%s got=%b want=%b t=%0t",
                   s, act, exp_v, $time);
        end
      end
    end
  end

  initial begin : stim
    // 1: reset
    drive(1, 0, 0, 0, 3'b111, 0, 0, 0);
    // 2: full packet to addr 2
    drive(0, 1, 2'b10, 0, 3'b111, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, 3'b111, 0, 0, 0);
    drive(0, 0, 0, 0, 3'b111, 0, 0, 0);
    drive(0, 0, 0, 0, 3'b111, 0, 0, 0);
    drive(0, 0, 0, 0, 3'b111, 0, 0, 0);
    drive(0, 0, 0, 0, 3'b111, 0, 0, 0);
    // 3: wait-till-empty on addr 1
    drive(0, 1, 2'b01, 0, 3'b101, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 3'b101, 0, 0, 0);
    drive(0, 1, 0, 0, 3'b111, 0, 0, 0);
    drive(0, 1, 0, 0, 3'b111, 0, 0, 0);
    // 4: full / load-after-full in LD
    drive(0, 1, 0, 1, 3'b111, 0, 0, 0);
    drive(0, 1, 0, 1, 3'b111, 0, 0, 0);
    drive(0, 1, 0, 0, 3'b111, 0, 0, 0);
    drive(0, 1, 0, 0, 3'b111, 0, 0, 0);
    drive(0, 1, 0, 1, 3'b111, 0, 0, 0);
    drive(0, 1, 0, 0, 3'b111, 0, 0, 0);
    drive(0, 0, 0, 0, 3'b111, 0, 0, 1);
    drive(0, 0, 0, 0, 3'b111, 0, 0, 0);
    drive(0, 0, 0, 0, 3'b111, 0, 0, 0);
    // 5: soft reset selectivity with addr_q=2, then reset in LFD
    drive(0, 1, 2'b10, 0, 3'b111, 0, 0, 0);
    drive(0, 1, 0, 0, 3'b111, 0, 0, 0);
    drive(0, 1, 0, 0, 3'b111, 3'b001, 0, 0);
    drive(0, 1, 0, 1, 3'b111, 3'b100, 0, 0);
    drive(0, 1, 2'b00, 0, 3'b111, 3'b111, 0, 0);
    drive(1, 1, 0, 0, 3'b111, 0, 0, 0);
    // 6: invalid address stays in DA
    drive(0, 1, 2'b11, 0, 3'b111, 0, 0, 0);
    drive(0, 1, 2'b11, 0, 3'b000, 0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic       r, pv, ff, pd, lpv;
      logic [1:0] din;
      logic [2:0] fe, sr;
      r   = ($urandom_range(0, 99) == 0);
      pv  = ($urandom_range(0, 4) != 0);
      din = 2'($urandom_range(0, 3));
      ff  = ($urandom_range(0, 3) == 0);
      fe  = 3'($urandom_range(0, 7));
      sr  = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      pd  = ($urandom_range(0, 2) == 0);
      lpv = ($urandom_range(0, 1) == 0);
      drive(r, pv, din, ff, fe, sr, pd, lpv);
    end
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
